// File: rtl/feeder_pkg.sv
// Shared definitions for the instruction feeder: FSM encoding, opcode field
// location, the MVI opcode and parameter defaults.
package feeder_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int TMO_DEF   = 15;

    localparam int         OP_MSB = 8;
    localparam int         OP_LSB = 6;
    localparam logic [2:0] OP_MVI = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        IMM   = 2'd2,
        WAIT  = 2'd3
    } feederState_t;

    function automatic logic isMvi(input logic [2:0] opcode);
        return opcode == OP_MVI;
    endfunction

    function automatic logic [1:0] wordsNeeded(input logic [2:0] opcode);
        return isMvi(opcode) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Instruction word FIFO: power-of-two storage, wrapping pointers, registered
// occupancy and full/empty flags, plus a peek at the word behind the head.
module feeder_fifo
    import feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic [15:0]                iWrData,
    input  logic                       iWrEn,
    input  logic                       iPop,
    output logic [15:0]                oHead,
    output logic [15:0]                oHeadNext,
    output logic [$clog2(DEPTH):0]     oCount,
    output logic                       oFull,
    output logic                       oEmpty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] nextCount;
    logic          push;
    logic          pop;

    // A full FIFO drops the write even when a pop frees a slot this cycle.
    assign push = iWrEn && !oFull;
    assign pop  = iPop && !oEmpty;

    assign oHead     = mem[rdPtr];
    assign oHeadNext = mem[rdPtr + AW'(1)];

    // NOTE: storage is deliberately left out of reset; pointers and count define validity.
    always_ff @(posedge iClk) begin
        if (push) begin
            mem[wrPtr] <= iWrData;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        nextCount = oCount;
        if (push && !pop) begin
            nextCount = oCount + CW'(1);
        end else if (pop && !push) begin
            nextCount = oCount - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            oCount <= '0;
            oFull  <= 1'b0;
            oEmpty <= 1'b1;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            oCount <= nextCount;
            oFull  <= (nextCount == CW'(DEPTH));
            oEmpty <= (nextCount == '0);
        end
    end

endmodule

// File: rtl/instr_feeder.sv
// Feeds buffered instruction words to a CPU: issues when the head instruction
// is complete in the FIFO, streams an MVI immediate, then waits for iDone or a timeout.
module instr_feeder
    import feeder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TMO   = TMO_DEF
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic [15:0]                iWrData,
    input  logic                       iWrEn,
    output logic                       oFull,
    output logic                       oEmpty,
    output logic [$clog2(DEPTH):0]     oCount,
    output logic [15:0]                oDIN,
    output logic                       oRun,
    input  logic                       iDone,
    output logic                       oBusy,
    output logic                       oTimeout
);

    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam int WCW  = $clog2(TMO + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TMO - 1);

    feederState_t    state;
    logic [WCW-1:0]  waitCnt;
    logic [15:0]     head;
    logic [15:0]     headNext;
    logic [2:0]      headOp;
    logic [CNTW-1:0] need;
    logic            pop;

    assign headOp = head[OP_MSB:OP_LSB];
    assign need   = CNTW'(wordsNeeded(headOp));
    assign pop    = (state == ISSUE) || (state == IMM);

    feeder_fifo #(
        .DEPTH(DEPTH)
    ) uFifo (
        .iClk     (iClk),
        .iRst     (iRst),
        .iWrData  (iWrData),
        .iWrEn    (iWrEn),
        .iPop     (pop),
        .oHead    (head),
        .oHeadNext(headNext),
        .oCount   (oCount),
        .oFull    (oFull),
        .oEmpty   (oEmpty)
    );

    // Outputs are loaded on the edge entering a state so they are valid throughout it.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= IDLE;
            waitCnt  <= '0;
            oDIN     <= 16'h0000;
            oRun     <= 1'b0;
            oBusy    <= 1'b0;
            oTimeout <= 1'b0;
        end else begin
            oRun     <= 1'b0;
            oTimeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (oCount >= need) begin
                        state <= ISSUE;
                        oDIN  <= head;
                        oRun  <= 1'b1;
                        oBusy <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (isMvi(headOp)) begin
                        state <= IMM;
                        oDIN  <= headNext;
                    end else begin
                        state   <= WAIT;
                        waitCnt <= '0;
                    end
                end
                IMM: begin
                    state   <= WAIT;
                    waitCnt <= '0;
                end
                WAIT: begin
                    // Completion wins over a timeout landing in the same cycle.
                    if (iDone) begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end else if (waitCnt == WAIT_LAST) begin
                        state    <= IDLE;
                        oBusy    <= 1'b0;
                        oTimeout <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + WCW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule
